// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // addi x0,x0,0 -- handed to the fetch stage when memory never answers
    localparam logic [ARB_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_REQ  = 2'd1,
        INSTR_REQ = 2'd2,
        DONE      = 2'd3
    } arb_state_e;

    // One pending access captured from the CPU while it is stalled
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } req_slot_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// CPU-side and memory-side bundles of the unified memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: cpu_stall on the CPU side, req/ack handshake on the memory side.
//
// mem_arb_cpu_if : master = CPU core, slave = arbiter
// mem_arb_mem_if : master = arbiter,  slave = memory
interface mem_arb_cpu_if #(
    parameter int ADDR_W = mem_arb_pkg::ARB_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::ARB_DATA_W
);
    logic              instr_read;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              data_read;
    logic              data_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              cpu_stall;
    logic              bus_err;

    modport master (
        output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        input  instr_out, instr_valid, data_out, data_valid, cpu_stall, bus_err
    );

    modport slave (
        input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
        output instr_out, instr_valid, data_out, data_valid, cpu_stall, bus_err
    );
endinterface

interface mem_arb_mem_if #(
    parameter int ADDR_W = mem_arb_pkg::ARB_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::ARB_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Request watchdog: counts cycles a memory request has gone unanswered.
// Latency: expired_o is combinational, asserted in the last allowed waiting cycle.
// Backpressure: none; counting pauses at TIMEOUT until cleared.
//
// Ports: clk, rst (async active-low), clr_i (restart from 0), inc_i (one more
// unanswered cycle), expired_o (this cycle is the TIMEOUT-th without an answer).
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Firing one count early lets the request drop at the same edge the
    // count would reach TIMEOUT, so mem_req is high for exactly TIMEOUT cycles.
    assign expired_o = inc_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port req/ack memory between instruction fetch and load/store.
// Latency: zero-wait memory -> fetch 3 cycles, fetch+data 5 cycles strobe-to-IDLE.
// Backpressure: cpu_stall holds the CPU while any access is pending; data served first.
//
// Ports: clk, rst (async active-low), cpu_s (CPU strobes/results, stall, bus_err),
// mem_m (memory req/we/addr/wdata out, rdata/ack in).
module unified_mem_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ARB_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::ARB_DATA_W,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = mem_arb_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    mem_arb_cpu_if.slave  cpu_s,
    mem_arb_mem_if.master mem_m
);
    import mem_arb_pkg::*;

    arb_state_e        state_q;
    req_slot_t         dslot_q;
    req_slot_t         islot_q;
    logic              mem_req_q;
    logic              data_valid_q;
    logic              instr_valid_q;
    logic              bus_err_q;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] instr_out_q;

    logic              any_strobe;
    logic              data_strobe;
    logic              tmr_expired;
    logic              xfer_end;
    logic              acked;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    assign data_strobe = cpu_s.data_read | cpu_s.data_write;
    assign any_strobe  = cpu_s.instr_read | data_strobe;

    // An ack only counts while a request is actually on the bus; this also
    // discards acks in the inter-request gap, in DONE/IDLE and after reset.
    assign acked    = mem_req_q & mem_m.mem_ack;
    assign xfer_end = mem_req_q & (mem_m.mem_ack | tmr_expired);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~mem_req_q),
        .inc_i     (mem_req_q & ~mem_m.mem_ack),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            dslot_q       <= '0;
            islot_q       <= '0;
            mem_req_q     <= 1'b0;
            data_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            data_out_q    <= '0;
            instr_out_q   <= '0;
        end else begin
            data_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_strobe) begin
                        // Read+write together is resolved as a write and flagged.
                        dslot_q <= '{valid: data_strobe,
                                     we:    cpu_s.data_write,
                                     addr:  cpu_s.data_addr,
                                     wdata: cpu_s.data_in};
                        islot_q <= '{valid: cpu_s.instr_read,
                                     we:    1'b0,
                                     addr:  cpu_s.instr_addr,
                                     wdata: '0};
                        mem_req_q <= 1'b1;
                        if (cpu_s.data_read && cpu_s.data_write) begin
                            bus_err_q <= 1'b1;
                        end
                        state_q <= data_strobe ? DATA_REQ : INSTR_REQ;
                    end
                end
                DATA_REQ: begin
                    if (xfer_end) begin
                        mem_req_q    <= 1'b0;
                        data_valid_q <= 1'b1;
                        if (!dslot_q.we) begin
                            data_out_q <= acked ? mem_m.mem_rdata : '0;
                        end
                        if (!acked) begin
                            bus_err_q <= 1'b1;
                        end
                        dslot_q <= '0;
                        state_q <= islot_q.valid ? INSTR_REQ : DONE;
                    end
                end
                INSTR_REQ: begin
                    if (!mem_req_q) begin
                        // Idle bus cycle after a data access, then issue the fetch.
                        mem_req_q <= 1'b1;
                    end else if (xfer_end) begin
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_out_q   <= acked ? mem_m.mem_rdata : NOP_INSTR;
                        if (!acked) begin
                            bus_err_q <= 1'b1;
                        end
                        islot_q <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Strobes seen here belong to the instruction now committing.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (state_q)
            DATA_REQ: begin
                if (dslot_q.valid) begin
                    mem_we_d    = dslot_q.we;
                    mem_addr_d  = dslot_q.addr;
                    mem_wdata_d = dslot_q.wdata;
                end
            end
            INSTR_REQ: begin
                mem_we_d    = islot_q.we;
                mem_addr_d  = islot_q.addr;
                mem_wdata_d = islot_q.wdata;
            end
            default: begin
            end
        endcase
    end

    assign mem_m.mem_req   = mem_req_q;
    assign mem_m.mem_we    = mem_we_d;
    assign mem_m.mem_addr  = mem_addr_d;
    assign mem_m.mem_wdata = mem_wdata_d;

    // Gated by rst so the stall falls the instant reset asserts, strobes or not.
    assign cpu_s.cpu_stall = rst & ((state_q == DATA_REQ) || (state_q == INSTR_REQ) ||
                                    ((state_q == IDLE) && any_strobe));

    assign cpu_s.instr_out   = instr_out_q;
    assign cpu_s.instr_valid = instr_valid_q;
    assign cpu_s.data_out    = data_out_q;
    assign cpu_s.data_valid  = data_valid_q;
    assign cpu_s.bus_err     = bus_err_q;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port memory between the CPU's instruction-fetch port and its load/store port.
- Sits between the CPU and a variable-latency memory that uses a req/ack handshake.
- Stalls the CPU while requests are outstanding.
- Serialises a simultaneous data access and instruction fetch, with data served first, and flags memory timeouts.

Parameters:
ADDR_W, 32, address width of the CPU and memory ports
DATA_W, 32, data width
TIMEOUT, 255, cycles a request waits for mem_ack before it is aborted (1..2^16-1)
NOP_INSTR, 32'h00000013, value returned on instr_out after a fetch timeout (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
instr_read  in  1  CPU fetch strobe
instr_addr  in  ADDR_W  fetch address
instr_out  out  DATA_W  fetched instruction, registered
instr_valid  out  1  one-cycle pulse: instr_out updated
data_read  in  1  CPU load strobe
data_write  in  1  CPU store strobe
data_addr  in  ADDR_W  load/store address
data_in  in  DATA_W  store data
data_out  out  DATA_W  load data, registered
data_valid  out  1  one-cycle pulse: load or store completed
cpu_stall  out  1  CPU must hold its state and strobes while high
mem_req  out  1  memory request, held high until mem_ack or timeout
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high
mem_ack  in  1  one-cycle completion from memory
bus_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0, except instr_out=0 and data_out=0.
  - Pending flags, latched address/data and timeout counter are cleared.
  - mem_req drops immediately, even mid-transaction. An in-flight mem_ack after reset is ignored.
- FSM states: IDLE, DATA_REQ, INSTR_REQ, DONE.
- cpu_stall is combinational:
  - 1 in DATA_REQ and INSTR_REQ.
  - 1 in IDLE when (instr_read | data_read | data_write).
  - 0 in DONE.
  - 0 in IDLE with no strobe.
- IDLE:
  - On any strobe, latch each requested address, data_in and direction into a pending slot (instr and data slots are separate).
  - Next state: DATA_REQ if a data slot is pending, else INSTR_REQ.
  - data_read & data_write together: treated as a write, bus_err<=1.
- DATA_REQ / INSTR_REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata driven from the slot; stable while mem_req is high.
  - Instruction fetch: mem_we=0, mem_wdata=0.
  - On mem_ack in DATA_REQ:
    - data_out<=mem_rdata on a read; data_out is unchanged on a write.
    - data_valid pulses next cycle; clear the slot.
    - Go to INSTR_REQ if the instr slot is pending, else DONE.
  - On mem_ack in INSTR_REQ: instr_out<=mem_rdata; instr_valid pulses next cycle; go to DONE.
  - mem_req drops in the cycle after mem_ack. Back-to-back requests therefore have one idle cycle between them.
- Timeout:
  - Counter is cleared on entry to each *_REQ state and increments each cycle without mem_ack.
  - When it reaches TIMEOUT: mem_req drops, bus_err<=1.
  - Completion then proceeds as if acked, with read data replaced: data_out<=0, or instr_out<=NOP_INSTR.
  - mem_ack in the same cycle as the timeout wins (normal completion, no error).
- DONE:
  - Lasts exactly one cycle with cpu_stall=0; the CPU commits at this edge.
  - Strobes are ignored in DONE (they are stale from the stalled instruction).
  - Next state: IDLE.
- Latency with a zero-wait memory (ack in the first mem_req cycle):
  - Fetch only: 3 cycles from strobe to next IDLE.
  - Fetch plus data: 5 cycles.
- bus_err clears only on reset.
- mem_ack outside *_REQ is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, DATA_REQ, INSTR_REQ, DONE};
  - constant NOP_INSTR;
  - width localparams;
  - a request-slot struct {valid, we, addr, wdata}.
- Sub-module mem_arb_timer: loadable/clearable timeout counter with a `expired` output. Its width is $clog2(TIMEOUT+1).

Test Plan:
- Fetch only, ack in the 1st req cycle, instr_addr=0x10, mem_rdata=0x00500093 -> mem_req=1 for 1 cycle with addr 0x10; instr_out=0x00500093; instr_valid pulses; cpu_stall high 2 cycles, low in DONE.
- Fetch plus load (data_addr=0x104, 3-cycle ack latency, rdata=0xDEADBEEF) -> data access issued first with mem_we=0; data_out=0xDEADBEEF; then fetch issued; cpu_stall high until DONE.
- Store (data_addr=0x200, data_in=0x12345678) -> mem_we=1 with that address and wdata held stable until ack; data_valid pulses; data_out unchanged.
- No ack, TIMEOUT=4 -> mem_req drops after 4 cycles; bus_err=1 (sticky); instr_out=0x00000013; FSM reaches DONE then IDLE.
- data_read & data_write together -> memory write performed, bus_err=1.
- rst asserted mid-DATA_REQ -> mem_req and cpu_stall drop asynchronously; a later ack is ignored; the next fetch works normally.
